// File: rtl/stage_1_2_pipe_if.sv
// Symbol-in / coded-out handshake bundle for the two-stage AV1 range/low update pipe.
interface stage_1_2_pipe_if #(
    parameter int unsigned RANGE_WIDTH  = 16,
    parameter int unsigned LOW_WIDTH    = 24,
    parameter int unsigned SYMBOL_WIDTH = 4,
    parameter int unsigned D_SIZE       = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    bool_mode;
    logic [RANGE_WIDTH-1:0]  FL;
    logic [RANGE_WIDTH-1:0]  FH;
    logic [SYMBOL_WIDTH-1:0] SYMBOL;
    logic [SYMBOL_WIDTH:0]   NSYMS;
    logic                    out_valid;
    logic                    out_ready;
    logic [RANGE_WIDTH-1:0]  range_out;
    logic [LOW_WIDTH-1:0]    low_out;
    logic                    carry_out;
    logic [D_SIZE-1:0]       d_out;

    modport master (output in_valid, bool_mode, FL, FH, SYMBOL, NSYMS, out_ready,
                    input  in_ready, out_valid, range_out, low_out, carry_out, d_out);
    modport slave  (input  in_valid, bool_mode, FL, FH, SYMBOL, NSYMS, out_ready,
                    output in_ready, out_valid, range_out, low_out, carry_out, d_out);
endinterface

// File: rtl/stage_1_2_pipe.sv
// Two-stage AV1 arithmetic-encoder range/low update with internally fed-back coder state.
// Stage 1 registers probability terms; stage 2 multiplies, updates low and normalises range.
module stage_1_2_pipe #(
    parameter int unsigned RANGE_WIDTH  = 16,
    parameter int unsigned LOW_WIDTH    = 24,
    parameter int unsigned SYMBOL_WIDTH = 4,
    parameter int unsigned D_SIZE       = 5,
    parameter int unsigned MIN_PROB     = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            init,
    stage_1_2_pipe_if.slave bus
);
    localparam int unsigned PROD_WIDTH = 2 * RANGE_WIDTH;
    localparam int unsigned SUM_WIDTH  = LOW_WIDTH + 1;
    localparam logic [RANGE_WIDTH-1:0] RANGE_INIT = {1'b1, {(RANGE_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                   bool_mode;
        logic                   bit_val;
        logic                   comp;
        logic [RANGE_WIDTH-1:0] uu;
        logic [RANGE_WIDTH-1:0] vv;
        logic [RANGE_WIDTH-1:0] lut_u;
        logic [RANGE_WIDTH-1:0] lut_v;
    } s1_t;

    logic                   en_c;
    logic                   accept_c;
    logic                   s1_valid;
    s1_t                    s1;
    s1_t                    s1_next_c;
    logic [RANGE_WIDTH-1:0] range_q;
    logic [LOW_WIDTH-1:0]   low_q;
    logic                   out_valid_q;
    logic [RANGE_WIDTH-1:0] range_out_q;
    logic [LOW_WIDTH-1:0]   low_out_q;
    logic                   carry_out_q;
    logic [D_SIZE-1:0]      d_out_q;

    logic [RANGE_WIDTH-1:0] r8_c;
    logic [PROD_WIDTH-1:0]  prod_u_c;
    logic [PROD_WIDTH-1:0]  prod_v_c;
    logic [RANGE_WIDTH-1:0] u_c;
    logic [RANGE_WIDTH-1:0] v_c;
    logic [RANGE_WIDTH-1:0] r_c;
    logic [RANGE_WIDTH-1:0] r_norm_c;
    logic [SUM_WIDTH-1:0]   low_sum_c;
    logic [D_SIZE-1:0]      msb_c;
    logic [D_SIZE-1:0]      d_c;

    // A stalled output freezes the whole pipe, including the fed-back state.
    assign en_c         = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en_c & ~init;
    assign accept_c     = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.range_out = range_out_q;
    assign bus.low_out   = low_out_q;
    assign bus.carry_out = carry_out_q;
    assign bus.d_out     = d_out_q;

    // Stage 1: probability terms; NSYMS-s equals N-(s-1).
    always_comb begin
        s1_next_c           = '0;
        s1_next_c.bool_mode = bus.bool_mode;
        s1_next_c.bit_val   = bus.SYMBOL[0];
        s1_next_c.vv        = bus.FH >> 6;
        if (bus.bool_mode) begin
            s1_next_c.lut_v = RANGE_WIDTH'(MIN_PROB);
        end else begin
            s1_next_c.comp  = bus.FL < RANGE_INIT;
            s1_next_c.uu    = bus.FL >> 6;
            s1_next_c.lut_u = RANGE_WIDTH'(MIN_PROB)
                            * (RANGE_WIDTH'(bus.NSYMS) - RANGE_WIDTH'(bus.SYMBOL));
            s1_next_c.lut_v = RANGE_WIDTH'(MIN_PROB)
                            * (RANGE_WIDTH'(bus.NSYMS) - RANGE_WIDTH'(bus.SYMBOL) - RANGE_WIDTH'(1));
        end
    end

    // Stage 2: range split, low update and leading-zero normalisation.
    always_comb begin
        r8_c      = range_q >> 8;
        prod_u_c  = PROD_WIDTH'(r8_c) * PROD_WIDTH'(s1.uu);
        prod_v_c  = PROD_WIDTH'(r8_c) * PROD_WIDTH'(s1.vv);
        u_c       = RANGE_WIDTH'(prod_u_c >> 1) + s1.lut_u;
        v_c       = RANGE_WIDTH'(prod_v_c >> 1) + s1.lut_v;
        low_sum_c = {1'b0, low_q};
        r_c       = range_q - v_c;
        if (s1.bool_mode) begin
            if (s1.bit_val) begin
                low_sum_c = {1'b0, low_q} + SUM_WIDTH'(range_q) - SUM_WIDTH'(v_c);
                r_c       = v_c;
            end
        end else if (s1.comp) begin
            low_sum_c = {1'b0, low_q} + SUM_WIDTH'(range_q) - SUM_WIDTH'(u_c);
            r_c       = u_c - v_c;
        end
        msb_c = '0;
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (r_c[i]) msb_c = D_SIZE'(i);
        end
        d_c      = D_SIZE'(RANGE_WIDTH - 1) - msb_c;
        r_norm_c = r_c << d_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            range_q     <= RANGE_INIT;
            low_q       <= '0;
            s1_valid    <= 1'b0;
            s1          <= '0;
            out_valid_q <= 1'b0;
            range_out_q <= '0;
            low_out_q   <= '0;
            carry_out_q <= 1'b0;
            d_out_q     <= '0;
        end else if (init) begin
            range_q     <= RANGE_INIT;
            low_q       <= '0;
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en_c) begin
            s1_valid <= accept_c;
            if (accept_c) s1 <= s1_next_c;
            if (s1_valid) begin
                range_out_q <= r_norm_c;
                low_out_q   <= low_sum_c[LOW_WIDTH-1:0];
                carry_out_q <= low_sum_c[LOW_WIDTH];
                d_out_q     <= d_c;
                out_valid_q <= 1'b1;
                range_q     <= r_norm_c;
                low_q       <= low_sum_c[LOW_WIDTH-1:0] << d_c;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stage_1_2_pipe.sv
// Directed bench for stage_1_2_pipe: hand-computed single-symbol table, chained streams, stall/init/reset.
module tb_stage_1_2_pipe;
    logic clk = 1'b0;
    logic reset_n;
    logic init;

    stage_1_2_pipe_if bus ();
    stage_1_2_pipe dut (.clk(clk), .reset_n(reset_n), .init(init), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] range;
        logic [23:0] low;
        logic        carry;
        logic [4:0]  d;
    } exp_t;

    typedef struct {
        bit          bmode;
        int unsigned fl, fh, sym, nsyms;
        int unsigned e_range, e_low, e_carry, e_d;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    bit          mon_en = 1'b0;
    bit          stalled = 1'b0;
    exp_t        snap;
    int unsigned mr = 32768;
    int unsigned ml = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          n_stall = 0;
    int          first_out = -1;
    int          last_out = -1;

    vec_t        vt[8];
    bit          sb[16];
    int unsigned sfl[16], sfh[16], ssym[16], sns[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference coder step written from the arithmetic definition (shift-until-normalised).
    task automatic model_step(input bit b, input int unsigned fl, fh, sym, nsyms,
                              input int unsigned rin, lin,
                              output int unsigned rout, lout, output exp_t e);
        int unsigned r8, u, v, r, d;
        longint unsigned lp;
        r8 = rin >> 8;
        v  = (((r8 * (fh >> 6)) >> 1) + (b ? 4 : 4 * (nsyms - 1 - sym))) & 32'hFFFF;
        u  = (((r8 * (fl >> 6)) >> 1) + 4 * (nsyms - sym)) & 32'hFFFF;
        if (b) begin
            if ((sym & 1) != 0) begin lp = 64'(lin + rin - v); r = v; end
            else begin lp = 64'(lin); r = rin - v; end
        end else if (fl < 32768) begin
            lp = 64'(lin + rin - u); r = u - v;
        end else begin
            lp = 64'(lin); r = rin - v;
        end
        lp = lp & 64'h1FFFFFF;
        r  = r & 32'hFFFF;
        d  = 0;
        while (r < 32768 && d < 16) begin r = r << 1; d++; end
        e.range = 16'(r);
        e.low   = 24'(lp);
        e.carry = lp[24];
        e.d     = 5'(d);
        rout    = r & 32'hFFFF;
        lout    = 32'(((lp & 64'hFFFFFF) << d) & 64'hFFFFFF);
    endtask

    task automatic do_init();
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic send(input bit b, input int unsigned fl, fh, sym, nsyms);
        int guard;
        guard         = 0;
        bus.bool_mode = b;
        bus.FL        = 16'(fl);
        bus.FH        = 16'(fh);
        bus.SYMBOL    = 4'(sym);
        bus.NSYMS     = 5'(nsyms);
        bus.in_valid  = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) check("send_timeout", 64'(guard), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin @(posedge clk); #1; guard++; end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    // Scoreboard: push model result on accept, compare on output handshake, verify stall freeze.
    always @(negedge clk) begin
        exp_t e;
        exp_t en;
        cyc++;
        if (mon_en) begin
            if (!reset_n || init) begin
                exp_q.delete();
                mr = 32768; ml = 0; stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_hold_range", bus.range_out, snap.range);
                    check("stall_hold_low", bus.low_out, snap.low);
                    check("stall_hold_d", bus.d_out, snap.d);
                end
                if (bus.out_valid && !bus.out_ready) begin
                    n_stall++;
                    check("stall_in_ready", bus.in_ready, 0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("out_unexpected", 64'(exp_q.size()), 1);
                    else begin
                        e = exp_q.pop_front();
                        check("stream_range", bus.range_out, e.range);
                        check("stream_low", bus.low_out, e.low);
                        check("stream_carry", bus.carry_out, e.carry);
                        check("stream_d", bus.d_out, e.d);
                        n_out++;
                        if (first_out < 0) first_out = cyc;
                        last_out = cyc;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    model_step(bus.bool_mode, bus.FL, bus.FH, bus.SYMBOL, bus.NSYMS, mr, ml, mr, ml, en);
                    exp_q.push_back(en);
                end
                stalled    = bus.out_valid && !bus.out_ready;
                snap.range = bus.range_out;
                snap.low   = bus.low_out;
                snap.carry = bus.carry_out;
                snap.d     = bus.d_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1234,  16384, 0, 2, 65520, 0,     0, 2};
        vt[1] = '{1'b1, 1234,  16384, 1, 2, 32776, 16380, 0, 1};
        vt[2] = '{1'b0, 32768, 16384, 0, 2, 65520, 0,     0, 2};
        vt[3] = '{1'b0, 16384, 0,     1, 2, 32776, 16380, 0, 1};
        vt[4] = '{1'b1, 999,   8192,  0, 2, 49144, 0,     0, 1};
        vt[5] = '{1'b1, 999,   8192,  1, 2, 32784, 24572, 0, 2};
        vt[6] = '{1'b0, 24576, 8192,  1, 4, 32776, 8180,  0, 1};
        vt[7] = '{1'b0, 4096,  0,     3, 4, 32800, 28668, 0, 3};
        for (int i = 0; i < 16; i++) begin
            sb[i] = 1'b1; sfl[i] = 0; sns[i] = 2;
        end
        sfh  = '{16384, 8192, 24576, 4096, 30000, 1000, 20000, 12345,
                 16384, 8192, 8192,  0,    16384, 20000, 500, 31000};
        ssym = '{1, 0, 1, 1, 0, 1, 0, 1,   0, 1, 1, 3, 1, 0, 1, 0};
        sb[10] = 1'b0; sfl[10] = 24576; sns[10] = 4;
        sb[11] = 1'b0; sfl[11] = 4096;  sns[11] = 4;
        sb[13] = 1'b0; sfl[13] = 32768; sns[13] = 4;

        reset_n = 1'b0; init = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.bool_mode = 1'b0;
        bus.FL = '0; bus.FH = '0; bus.SYMBOL = '0; bus.NSYMS = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_range_out", bus.range_out, 0);
        check("rst_low_out", bus.low_out, 0);
        check("rst_carry_out", bus.carry_out, 0);
        check("rst_d_out", bus.d_out, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Symbol presented during init is dropped.
        init = 1'b1; bus.in_valid = 1'b1; bus.bool_mode = 1'b1; bus.FH = 16'd16384; bus.SYMBOL = 4'd1;
        #1 check("init_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        init = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("init_drop_a", bus.out_valid, 0);
        @(posedge clk); #1;
        check("init_drop_b", bus.out_valid, 0);

        for (int i = 0; i < 8; i++) begin
            do_init();
            send(vt[i].bmode, vt[i].fl, vt[i].fh, vt[i].sym, vt[i].nsyms);
            check($sformatf("vec%0d_lat1", i), bus.out_valid, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            check($sformatf("vec%0d_range", i), bus.range_out, vt[i].e_range);
            check($sformatf("vec%0d_low", i), bus.low_out, vt[i].e_low);
            check($sformatf("vec%0d_carry", i), bus.carry_out, vt[i].e_carry);
            check($sformatf("vec%0d_d", i), bus.d_out, vt[i].e_d);
        end

        // Back-to-back: second symbol sees low=32760 left by the first.
        do_init();
        send(1'b1, 0, 16384, 1, 2);
        check("b2b_lat", bus.out_valid, 0);
        send(1'b1, 0, 16384, 0, 2);
        check("b2b_a_valid", bus.out_valid, 1);
        check("b2b_a_range", bus.range_out, 32776);
        check("b2b_a_low", bus.low_out, 16380);
        @(posedge clk); #1;
        check("b2b_b_valid", bus.out_valid, 1);
        check("b2b_b_range", bus.range_out, 32776);
        check("b2b_b_low", bus.low_out, 32760);
        check("b2b_b_d", bus.d_out, 1);
        @(posedge clk); #1;
        check("b2b_idle_valid", bus.out_valid, 0);
        check("b2b_idle_hold", bus.range_out, 32776);

        // Stream of 8 bool symbols, no stall.
        mon_en = 1'b1;
        do_init();
        n_out = 0; first_out = -1; last_out = -1;
        for (int k = 0; k < 8; k++) send(sb[k], sfl[k], sfh[k], ssym[k], sns[k]);
        drain();
        check("stream1_count", 64'(n_out), 8);
        check("stream1_contig", 64'(last_out - first_out), 7);

        // Mixed stream with a 3-cycle downstream stall.
        do_init();
        n_out = 0; n_stall = 0;
        fork
            begin
                for (int k = 8; k < 16; k++) send(sb[k], sfl[k], sfh[k], ssym[k], sns[k]);
            end
            begin
                repeat (4) @(posedge clk); #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream2_count", 64'(n_out), 8);
        check("stream2_stalls", 64'(n_stall), 3);

        // init during a stall with two symbols in flight.
        bus.out_ready = 1'b0;
        send(1'b1, 0, 16384, 1, 2);
        send(1'b1, 0, 8192, 1, 2);
        check("init_flight_valid", bus.out_valid, 1);
        do_init();
        check("init_flush_a", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("init_flush_b", bus.out_valid, 0);
        n_out = 0;
        send(1'b1, 0, 16384, 0, 2);
        drain();
        check("init_after_count", 64'(n_out), 1);

        // Async reset mid-stream.
        send(1'b1, 0, 20000, 1, 2);
        send(1'b1, 0, 3000, 0, 2);
        check("rst_mid_pre", bus.out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_range", bus.range_out, 0);
        check("rst_mid_low", bus.low_out, 0);
        check("rst_mid_d", bus.d_out, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_out = 0;
        send(1'b1, 0, 16384, 1, 2);
        drain();
        check("rst_after_count", 64'(n_out), 1);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
